// File: rtl/video_scan_timing.sv
// Raster timing generator: pixel strobe by integer division, h/v counts, syncs, DE, cell coords.
// Outputs register on the clk after each o_pix_ce and hold PIX_DIV clks; free-running, no backpressure.
module video_scan_timing #(
    parameter int PIX_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CELL_W   = 8,
    parameter int CELL_H   = 8,
    parameter int HSZ      = 10,
    parameter int VSZ      = 10
) (
    input  logic           clk_100mhz,
    input  logic           rstn_i,
    input  logic           i_enable,
    output logic           o_pix_ce,
    output logic [HSZ-1:0] o_hcount,
    output logic [VSZ-1:0] o_vcount,
    output logic           o_de,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_line_start,
    output logic           o_frame_start,
    output logic [HSZ-1:0] o_glyph_x,
    output logic [VSZ-1:0] o_glyph_y,
    output logic [HSZ-1:0] o_cell_x,
    output logic [VSZ-1:0] o_cell_y,
    output logic [7:0]     o_frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0]  DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [HSZ-1:0] H_LAST   = HSZ'(H_TOTAL - 1);
    localparam logic [HSZ-1:0] H_ACT    = HSZ'(H_ACTIVE);
    localparam logic [HSZ-1:0] H_ACT_M1 = HSZ'(H_ACTIVE - 1);
    localparam logic [HSZ-1:0] HS_BEG   = HSZ'(H_ACTIVE + H_FP);
    localparam logic [HSZ-1:0] HS_LAST  = HSZ'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HSZ-1:0] GX_LAST  = HSZ'(CELL_W - 1);
    localparam logic [VSZ-1:0] V_LAST   = VSZ'(V_TOTAL - 1);
    localparam logic [VSZ-1:0] V_ACT    = VSZ'(V_ACTIVE);
    localparam logic [VSZ-1:0] V_ACT_M1 = VSZ'(V_ACTIVE - 1);
    localparam logic [VSZ-1:0] VS_BEG   = VSZ'(V_ACTIVE + V_FP);
    localparam logic [VSZ-1:0] VS_LAST  = VSZ'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VSZ-1:0] GY_LAST  = VSZ'(CELL_H - 1);

    typedef struct packed {
        logic [HSZ-1:0] h;
        logic [HSZ-1:0] gx;
        logic [HSZ-1:0] cx;
        logic [VSZ-1:0] v;
        logic [VSZ-1:0] gy;
        logic [VSZ-1:0] cy;
        logic [7:0]     fc;
    } pos_t;

    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic          pce;
    // nxt is the position the next strobe will present, so the first strobe shows (0,0)
    pos_t          nxt;
    pos_t          adv;
    pos_t          cur;
    logic          de_q, hs_q, vs_q, ls_q, fs_q;
    logic          h_wrap, v_wrap;
    logic          nxt_de, nxt_hs, nxt_vs;

    assign div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
    assign h_wrap  = (nxt.h == H_LAST);
    assign v_wrap  = (nxt.v == V_LAST);
    assign nxt_de  = (nxt.h < H_ACT) && (nxt.v < V_ACT);
    assign nxt_hs  = (nxt.h >= HS_BEG && nxt.h <= HS_LAST) ? HS_POL : ~HS_POL;
    assign nxt_vs  = (nxt.v >= VS_BEG && nxt.v <= VS_LAST) ? VS_POL : ~VS_POL;

    always_comb begin
        adv = nxt;
        if (h_wrap) begin
            adv.h  = '0;
            adv.gx = '0;
            adv.cx = '0;
            if (v_wrap) begin
                adv.v  = '0;
                adv.gy = '0;
                adv.cy = '0;
                adv.fc = nxt.fc + 8'd1;
            end else begin
                adv.v = nxt.v + 1'b1;
                // rows stop advancing once the last active line is done
                if (nxt.v < V_ACT_M1) begin
                    if (nxt.gy == GY_LAST) begin
                        adv.gy = '0;
                        adv.cy = nxt.cy + 1'b1;
                    end else begin
                        adv.gy = nxt.gy + 1'b1;
                    end
                end
            end
        end else begin
            adv.h = nxt.h + 1'b1;
            if (nxt.h < H_ACT_M1) begin
                if (nxt.gx == GX_LAST) begin
                    adv.gx = '0;
                    adv.cx = nxt.cx + 1'b1;
                end else begin
                    adv.gx = nxt.gx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            div  <= '0;
            pce  <= 1'b0;
            nxt  <= '0;
            cur  <= '0;
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
        end else if (!i_enable) begin
            div  <= '0;
            pce  <= 1'b0;
            nxt  <= '0;
            cur  <= '0;
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
        end else begin
            div <= div_nxt;
            pce <= (div_nxt == DIV_LAST);
            if (pce) begin
                cur  <= nxt;
                de_q <= nxt_de;
                hs_q <= nxt_hs;
                vs_q <= nxt_vs;
                ls_q <= (nxt.h == '0);
                fs_q <= (nxt.h == '0) && (nxt.v == '0);
                nxt  <= adv;
            end
        end
    end

    assign o_pix_ce      = pce;
    assign o_hcount      = cur.h;
    assign o_vcount      = cur.v;
    assign o_de          = de_q;
    assign o_hsync       = hs_q;
    assign o_vsync       = vs_q;
    assign o_line_start  = ls_q;
    assign o_frame_start = fs_q;
    assign o_glyph_x     = cur.gx;
    assign o_glyph_y     = cur.gy;
    assign o_cell_x      = cur.cx;
    assign o_cell_y      = cur.cy;
    assign o_frame_cnt   = cur.fc;

endmodule

// File: tb/tb_video_scan_timing.sv
// Scoreboard bench: three configurations (defaults, small raster, small raster with inverted syncs).
module tb_video_scan_timing;

    localparam int NF = 15;
    localparam int F_H = 0, F_V = 1, F_DE = 2, F_HS = 3, F_VS = 4, F_LS = 5, F_FS = 6;
    localparam int F_GX = 7, F_GY = 8, F_CX = 9, F_CY = 10, F_FC = 11, F_PCE = 12;
    localparam int F_CYC = 13, F_REL = 14;

    typedef struct {
        int    dut;
        int    idx;
        string nm;
        int    f[NF];
    } exp_t;

    string fnames[NF] = '{"h", "v", "de", "hs", "vs", "ls", "fs", "gx", "gy", "cx", "cy",
                          "fc", "pce", "cyc", "rel"};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rstn;
    logic [2:0]       en;
    logic [2:0]       pce, de, hs, vs, ls, fs;
    logic [2:0][9:0]  hc, vc, gx, gy, cx, cy;
    logic [2:0][7:0]  fc;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    video_scan_timing u0 (
        .clk_100mhz(clk), .rstn_i(rstn[0]), .i_enable(en[0]), .o_pix_ce(pce[0]),
        .o_hcount(hc[0]), .o_vcount(vc[0]), .o_de(de[0]), .o_hsync(hs[0]), .o_vsync(vs[0]),
        .o_line_start(ls[0]), .o_frame_start(fs[0]), .o_glyph_x(gx[0]), .o_glyph_y(gy[0]),
        .o_cell_x(cx[0]), .o_cell_y(cy[0]), .o_frame_cnt(fc[0]));

    video_scan_timing #(
        .PIX_DIV(1), .H_ACTIVE(10), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(1), .V_BP(1), .CELL_W(3), .CELL_H(2)
    ) u1 (
        .clk_100mhz(clk), .rstn_i(rstn[1]), .i_enable(en[1]), .o_pix_ce(pce[1]),
        .o_hcount(hc[1]), .o_vcount(vc[1]), .o_de(de[1]), .o_hsync(hs[1]), .o_vsync(vs[1]),
        .o_line_start(ls[1]), .o_frame_start(fs[1]), .o_glyph_x(gx[1]), .o_glyph_y(gy[1]),
        .o_cell_x(cx[1]), .o_cell_y(cy[1]), .o_frame_cnt(fc[1]));

    video_scan_timing #(
        .PIX_DIV(2), .H_ACTIVE(10), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(1), .V_BP(1), .CELL_W(3), .CELL_H(2),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u2 (
        .clk_100mhz(clk), .rstn_i(rstn[2]), .i_enable(en[2]), .o_pix_ce(pce[2]),
        .o_hcount(hc[2]), .o_vcount(vc[2]), .o_de(de[2]), .o_hsync(hs[2]), .o_vsync(vs[2]),
        .o_line_start(ls[2]), .o_frame_start(fs[2]), .o_glyph_x(gx[2]), .o_glyph_y(gy[2]),
        .o_cell_x(cx[2]), .o_cell_y(cy[2]), .o_frame_cnt(fc[2]));

    function automatic exp_t mk(int dut, int idx, string nm);
        exp_t e;
        e.dut = dut;
        e.idx = idx;
        e.nm  = nm;
        for (int i = 0; i < NF; i++) e.f[i] = -1;
        return e;
    endfunction

    function automatic exp_t ev(int dut, int idx, string nm, int h, int v, int d_e,
                                int h_s, int v_s, int g_x, int c_x);
        exp_t e;
        e = mk(dut, idx, nm);
        e.f[F_H]  = h;   e.f[F_V]  = v;   e.f[F_DE] = d_e;
        e.f[F_HS] = h_s; e.f[F_VS] = v_s; e.f[F_GX] = g_x; e.f[F_CX] = c_x;
        return e;
    endfunction

    function automatic exp_t snap(int d);
        exp_t o;
        o = mk(d, 0, "obs");
        o.f[F_H]  = int'(hc[d]); o.f[F_V]  = int'(vc[d]); o.f[F_DE] = int'(de[d]);
        o.f[F_HS] = int'(hs[d]); o.f[F_VS] = int'(vs[d]); o.f[F_LS] = int'(ls[d]);
        o.f[F_FS] = int'(fs[d]); o.f[F_GX] = int'(gx[d]); o.f[F_GY] = int'(gy[d]);
        o.f[F_CX] = int'(cx[d]); o.f[F_CY] = int'(cy[d]); o.f[F_FC] = int'(fc[d]);
        o.f[F_PCE] = int'(pce[d]);
        return o;
    endfunction

    task automatic cmp(exp_t e, exp_t o);
        bit bad;
        bad = 1'b0;
        n_cmp++;
        for (int i = 0; i < NF; i++) begin
            if (e.f[i] != -1 && e.f[i] != o.f[i]) begin
                bad = 1'b1;
                $display("FAIL %s dut%0d idx%0d %s: got %0d expected %0d",
                         e.nm, e.dut, e.idx, fnames[i], o.f[i], e.f[i]);
            end
        end
        if (bad) n_bad++;
    endtask

    task automatic chk_rst(int d, string nm, int hsi, int vsi);
        exp_t e;
        e = ev(d, -1, nm, 0, 0, 0, hsi, vsi, 0, 0);
        e.f[F_LS] = 0; e.f[F_FS] = 0; e.f[F_GY] = 0; e.f[F_CY] = 0;
        e.f[F_FC] = 0; e.f[F_PCE] = 0;
        cmp(e, snap(d));
    endtask

    task automatic drain(int limit, string nm);
        int n;
        n = 0;
        while (q.size() > 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            $display("FAIL %s timeout: %0d expected outputs never presented, next idx %0d",
                     nm, q.size(), q[0].idx);
            n_cmp++;
            n_bad++;
            q.delete();
        end
        #1;
    endtask

    // Monitor: numbers each fresh output set per DUT since the last restart
    int k[3], cyc[3], cyc0[3];
    bit pprev[3];
    always @(negedge clk) begin
        exp_t o;
        for (int d = 0; d < 3; d++) begin
            if (!rstn[d] || !en[d]) begin
                k[d] = 0; cyc[d] = 0; pprev[d] = 1'b0;
            end else begin
                cyc[d]++;
                if (pprev[d]) begin
                    o = snap(d);
                    if (k[d] == 0) cyc0[d] = cyc[d];
                    o.idx = k[d];
                    o.f[F_CYC] = cyc[d];
                    o.f[F_REL] = cyc[d] - cyc0[d];
                    if (q.size() > 0 && q[0].dut == d && q[0].idx == k[d]) begin
                        cmp(q[0], o);
                        void'(q.pop_front());
                    end
                    k[d]++;
                end
                pprev[d] = pce[d];
            end
        end
    end

    int cx_tab[16] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3};
    int gx_tab[16] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0};
    int cy_tab[8]  = '{0, 0, 1, 1, 2, 2, 2, 2};
    int gy_tab[8]  = '{0, 1, 0, 1, 0, 0, 0, 0};

    initial begin
        exp_t e;
        rstn = 3'b000;
        en   = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst(0, "rst0", 1, 1);
        chk_rst(1, "rst1", 1, 1);
        chk_rst(2, "rst2", 0, 0);

        // Defaults: first strobe, first line, hsync window, DE edge, second line
        e = ev(0, 0, "first", 0, 0, 1, 1, 1, 0, 0);
        e.f[F_LS] = 1; e.f[F_FS] = 1; e.f[F_GY] = 0; e.f[F_CY] = 0; e.f[F_FC] = 0; e.f[F_CYC] = 5;
        q.push_back(e);
        e = ev(0, 1, "px1", 1, 0, 1, 1, 1, 1, 0);
        e.f[F_LS] = 0; e.f[F_FS] = 0; e.f[F_CYC] = 9; e.f[F_REL] = 4;
        q.push_back(e);
        q.push_back(ev(0, 8, "cell1", 8, 0, 1, 1, 1, 0, 1));
        q.push_back(ev(0, 639, "lastact", 639, 0, 1, 1, 1, 7, 79));
        q.push_back(ev(0, 640, "defall", 640, 0, 0, 1, 1, 7, 79));
        q.push_back(ev(0, 655, "hspre", 655, 0, 0, 1, 1, 7, 79));
        q.push_back(ev(0, 656, "hsbeg", 656, 0, 0, 0, 1, 7, 79));
        q.push_back(ev(0, 751, "hsend", 751, 0, 0, 0, 1, 7, 79));
        q.push_back(ev(0, 752, "hspost", 752, 0, 0, 1, 1, 7, 79));
        q.push_back(ev(0, 799, "eol", 799, 0, 0, 1, 1, 7, 79));
        e = ev(0, 800, "line1", 0, 1, 1, 1, 1, 0, 0);
        e.f[F_LS] = 1; e.f[F_FS] = 0; e.f[F_GY] = 1; e.f[F_CY] = 0; e.f[F_REL] = 3200;
        q.push_back(e);
        e = ev(0, 1100, "mid", 300, 1, 1, 1, 1, 4, 37);
        e.f[F_GY] = 1;
        q.push_back(e);
        @(posedge clk); #1;
        rstn[0] = 1'b1;
        en[0]   = 1'b1;
        drain(5000, "u0run");

        // Enable drop at (300,1), restart 10 clks later
        en[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_rst(0, "endis", 1, 1);
        e = ev(0, 0, "reen", 0, 0, 1, 1, 1, 0, 0);
        e.f[F_FS] = 1; e.f[F_FC] = 0; e.f[F_CY] = 0; e.f[F_CYC] = 5;
        q.push_back(e);
        e = ev(0, 300, "prerst", 300, 0, 1, 1, 1, 4, 37);
        q.push_back(e);
        repeat (9) @(posedge clk);
        #1;
        en[0] = 1'b1;
        drain(2000, "u0reen");

        // Asynchronous reset pulse mid-line
        rstn[0] = 1'b0;
        #1;
        chk_rst(0, "arst", 1, 1);
        e = ev(0, 0, "rerst", 0, 0, 1, 1, 1, 0, 0);
        e.f[F_FS] = 1; e.f[F_CYC] = 5;
        q.push_back(e);
        repeat (3) @(posedge clk);
        #1;
        rstn[0] = 1'b1;
        drain(100, "u0rerst");
        en[0]   = 1'b0;
        rstn[0] = 1'b0;

        // Small raster, PIX_DIV=1: full first frame from hand tables, then frame counter wrap
        for (int v = 0; v < 8; v++) begin
            for (int h = 0; h < 16; h++) begin
                e = ev(1, v * 16 + h, "t4", h, v, (h < 10 && v < 5) ? 1 : 0,
                       (h == 12 || h == 13) ? 0 : 1, (v == 6) ? 0 : 1, gx_tab[h], cx_tab[h]);
                e.f[F_GY] = gy_tab[v]; e.f[F_CY] = cy_tab[v];
                e.f[F_LS] = (h == 0) ? 1 : 0; e.f[F_FS] = (h == 0 && v == 0) ? 1 : 0;
                e.f[F_FC] = 0; e.f[F_REL] = v * 16 + h;
                q.push_back(e);
            end
        end
        e = ev(1, 128, "f1", 0, 0, 1, 1, 1, 0, 0);
        e.f[F_GY] = 0; e.f[F_CY] = 0; e.f[F_FC] = 1; e.f[F_FS] = 1; e.f[F_REL] = 128;
        q.push_back(e);
        e = ev(1, 32639, "f254end", 15, 7, 0, 1, 1, 0, 3);
        e.f[F_GY] = 0; e.f[F_CY] = 2; e.f[F_FC] = 254;
        q.push_back(e);
        e = ev(1, 32640, "f255", 0, 0, 1, 1, 1, 0, 0);
        e.f[F_FC] = 255; e.f[F_FS] = 1; e.f[F_CY] = 0;
        q.push_back(e);
        e = ev(1, 32768, "fcwrap", 0, 0, 1, 1, 1, 0, 0);
        e.f[F_FC] = 0; e.f[F_FS] = 1; e.f[F_GY] = 0; e.f[F_CY] = 0;
        q.push_back(e);
        e = ev(1, 32835, "f256c", 3, 4, 1, 1, 1, 0, 1);
        e.f[F_FC] = 0; e.f[F_GY] = 0; e.f[F_CY] = 2;
        q.push_back(e);
        rstn[1] = 1'b1;
        en[1]   = 1'b1;
        drain(40000, "u1run");
        en[1]   = 1'b0;
        rstn[1] = 1'b0;

        // Inverted sync polarity, PIX_DIV=2
        e = ev(2, 0, "pfirst", 0, 0, 1, 0, 0, 0, 0);
        e.f[F_FS] = 1; e.f[F_CYC] = 3;
        q.push_back(e);
        q.push_back(ev(2, 11, "phs11", 11, 0, 0, 0, 0, 0, 3));
        e = ev(2, 12, "phs12", 12, 0, 0, 1, 0, 0, 3);
        e.f[F_REL] = 24;
        q.push_back(e);
        q.push_back(ev(2, 13, "phs13", 13, 0, 0, 1, 0, 0, 3));
        q.push_back(ev(2, 14, "phs14", 14, 0, 0, 0, 0, 0, 3));
        e = ev(2, 80, "pv5", 0, 5, 0, 0, 0, 0, 0);
        e.f[F_GY] = 0; e.f[F_CY] = 2;
        q.push_back(e);
        q.push_back(ev(2, 96, "pvs", 0, 6, 0, 0, 1, 0, 0));
        q.push_back(ev(2, 109, "pvshs", 13, 6, 0, 1, 1, 0, 3));
        q.push_back(ev(2, 112, "pv7", 0, 7, 0, 0, 0, 0, 0));
        e = ev(2, 128, "pf1", 0, 0, 1, 0, 0, 0, 0);
        e.f[F_FC] = 1; e.f[F_REL] = 256;
        q.push_back(e);
        rstn[2] = 1'b1;
        en[2]   = 1'b1;
        drain(1000, "u2run");
        en[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_rst(2, "pdis", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
